// File: rtl/cordic_vec_pkg.sv
// Shared constants for the vectoring CORDIC and its rotation-PE counterpart.
package cordic_vec_pkg;

  localparam int PIPE_NUM = 4;

  // CORDIC gain compensation 1/K ~ 0.60725 in Q1.14
  localparam logic [14:0] K_CORDIC = 15'b010011011011101;

  // Iteration split across the three iteration stages; the rotation PE uses the same split
  localparam int S0_FIRST = 0;
  localparam int S0_LAST  = 3;
  localparam int S1_FIRST = 4;
  localparam int S1_LAST  = 8;
  localparam int S2_FIRST = 9;
  localparam int S2_LAST  = 13;

endpackage

// File: rtl/cordic_vec_iter.sv
// One combinational vectoring micro-rotation: steer Y toward zero by 2^-shift.
module cordic_vec_iter
  import cordic_vec_pkg::*;
#(
  parameter int WIDTH   = 19,
  parameter int SHIFT_W = 4
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic [SHIFT_W-1:0]      shift,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic                    d
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;

  assign x_sh = x >>> shift;
  assign y_sh = y >>> shift;

  // Negative Y rotates counter-clockwise; Y == 0 counts as non-negative
  assign d      = y[WIDTH-1];
  assign x_next = d ? (x - y_sh) : (x + y_sh);
  assign y_next = d ? (y + x_sh) : (y - x_sh);

endmodule

// File: rtl/cordic_vec.sv
// Vectoring CORDIC boundary cell: emits direction bits and K-scaled magnitude,
// pipelined in four stages to match the rotation PE latency.
module cordic_vec
  import cordic_vec_pkg::*;
#(
  parameter int BITWIDTH   = 18,
  parameter int CORDIC_NUM = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [BITWIDTH-1:0]   X_i,
  input  logic [BITWIDTH-1:0]   Y_i,
  output logic                  valid_o,
  output logic [BITWIDTH-1:0]   X_o,
  output logic [CORDIC_NUM-1:0] d_o,
  output logic                  flip_o
);

  localparam int W  = BITWIDTH + 1;
  localparam int SW = $clog2(CORDIC_NUM);
  localparam int PW = BITWIDTH + 17;

  logic signed [W-1:0] x_ext, y_ext, x_pre, y_pre;
  logic                flip_pre;

  logic signed [W-1:0] x_in  [CORDIC_NUM];
  logic signed [W-1:0] y_in  [CORDIC_NUM];
  logic signed [W-1:0] x_out [CORDIC_NUM];
  logic signed [W-1:0] y_out [CORDIC_NUM];
  logic [CORDIC_NUM-1:0] d_it;

  logic                v0, v1, v2;
  logic signed [W-1:0] s0_x, s0_y, s1_x, s1_y, s2_x;
  logic [S0_LAST:0]    s0_d;
  logic [S1_LAST:0]    s1_d;
  logic [CORDIC_NUM-1:0] s2_d;
  logic                s0_flip, s1_flip, s2_flip;

  logic signed [PW-1:0] prod;
  logic                 unused_bits;

  // Left half-plane inputs are pre-rotated by 180 degrees; extension keeps -2^(BITWIDTH-1) exact
  assign x_ext    = {X_i[BITWIDTH-1], X_i};
  assign y_ext    = {Y_i[BITWIDTH-1], Y_i};
  assign flip_pre = X_i[BITWIDTH-1];
  assign x_pre    = flip_pre ? -x_ext : x_ext;
  assign y_pre    = flip_pre ? -y_ext : y_ext;

  for (genvar i = 0; i < CORDIC_NUM; i++) begin : g_iter
    if (i == S0_FIRST) begin : g_src_pre
      assign x_in[i] = x_pre;
      assign y_in[i] = y_pre;
    end else if (i == S1_FIRST) begin : g_src_s0
      assign x_in[i] = s0_x;
      assign y_in[i] = s0_y;
    end else if (i == S2_FIRST) begin : g_src_s1
      assign x_in[i] = s1_x;
      assign y_in[i] = s1_y;
    end else begin : g_src_chain
      assign x_in[i] = x_out[i-1];
      assign y_in[i] = y_out[i-1];
    end

    cordic_vec_iter #(
      .WIDTH   (W),
      .SHIFT_W (SW)
    ) u_iter (
      .x      (x_in[i]),
      .y      (y_in[i]),
      .shift  (SW'(i)),
      .x_next (x_out[i]),
      .y_next (y_out[i]),
      .d      (d_it[i])
    );
  end

  assign prod = $signed({{(PW-W){s2_x[W-1]}}, s2_x}) * $signed({{(PW-15){1'b0}}, K_CORDIC});

  // Residual Y after the last iteration and the dropped product bits are intentionally discarded
  assign unused_bits = ^{prod[13:0], prod[PW-1:BITWIDTH+14], y_out[CORDIC_NUM-1]};

  // Valid chain advances every cycle; stage payloads load only behind a valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      valid_o <= 1'b0;
      s0_x    <= '0;
      s0_y    <= '0;
      s0_d    <= '0;
      s0_flip <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_d    <= '0;
      s1_flip <= 1'b0;
      s2_x    <= '0;
      s2_d    <= '0;
      s2_flip <= 1'b0;
      X_o     <= '0;
      d_o     <= '0;
      flip_o  <= 1'b0;
    end else begin
      v0      <= valid_i;
      v1      <= v0;
      v2      <= v1;
      valid_o <= v2;
      if (valid_i) begin
        s0_x    <= x_out[S0_LAST];
        s0_y    <= y_out[S0_LAST];
        s0_d    <= d_it[S0_LAST:S0_FIRST];
        s0_flip <= flip_pre;
      end
      if (v0) begin
        s1_x    <= x_out[S1_LAST];
        s1_y    <= y_out[S1_LAST];
        s1_d    <= {d_it[S1_LAST:S1_FIRST], s0_d};
        s1_flip <= s0_flip;
      end
      if (v1) begin
        s2_x    <= x_out[S2_LAST];
        s2_d    <= {d_it[S2_LAST:S2_FIRST], s1_d};
        s2_flip <= s1_flip;
      end
      if (v2) begin
        X_o    <= prod[BITWIDTH+13:14];
        d_o    <= s2_d;
        flip_o <= s2_flip;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vec.sv
// Self-checking bench for cordic_vec against a plain-arithmetic CORDIC model.
module tb_cordic_vec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [17:0] X_i = '0;
  logic [17:0] Y_i = '0;
  logic        valid_o;
  logic [17:0] X_o;
  logic [13:0] d_o;
  logic        flip_o;

  typedef struct {
    logic [17:0] x;
    logic [13:0] d;
    logic        f;
  } res_t;

  res_t        q[$];
  res_t        last;
  logic [3:0]  vpipe;
  int          total = 0;
  int          bad = 0;
  longint      xs, ys, xo;

  localparam longint K_VAL = 9949;

  cordic_vec dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .X_i     (X_i),
    .Y_i     (Y_i),
    .valid_o (valid_o),
    .X_o     (X_o),
    .d_o     (d_o),
    .flip_o  (flip_o)
  );

  always #5 clk = ~clk;

  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = (64'sd1 <<< w) - 1;
    v = v & m;
    if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
    return v;
  endfunction

  // Reference: flip into right half-plane, greedily zero Y over 14 halving steps, scale by K
  function automatic res_t ref_model(input longint xi, input longint yi);
    res_t   r;
    longint x, y, xn, yn;
    r.f = (xi < 0);
    x = r.f ? -xi : xi;
    y = r.f ? -yi : yi;
    r.d = '0;
    for (int i = 0; i < 14; i++) begin
      r.d[i] = (y < 0);
      if (r.d[i]) begin xn = x - (y >>> i); yn = y + (x >>> i); end
      else        begin xn = x + (y >>> i); yn = y - (x >>> i); end
      x = wrap(xn, 19);
      y = wrap(yn, 19);
    end
    r.x = 18'(wrap((x * K_VAL) >>> 14, 18));
    return r;
  endfunction

  // Rotation PE: apply a given direction word and scale both components
  task automatic rot_pe(input longint xi, input longint yi, input logic [13:0] d,
                        output longint xo_s, output longint yo_s);
    longint x, y, xn, yn;
    x = xi;
    y = yi;
    for (int i = 0; i < 14; i++) begin
      if (d[i]) begin xn = x - (y >>> i); yn = y + (x >>> i); end
      else      begin xn = x + (y >>> i); yn = y - (x >>> i); end
      x = wrap(xn, 19);
      y = wrap(yn, 19);
    end
    xo_s = wrap((x * K_VAL) >>> 14, 18);
    yo_s = (y * K_VAL) >>> 14;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance, then check outputs against the in-order scoreboard
  task automatic cycle(input logic v, input longint x, input longint y);
    res_t e;
    valid_i = v;
    X_i = 18'(x);
    Y_i = 18'(y);
    if (v) q.push_back(ref_model(x, y));
    @(posedge clk);
    @(negedge clk);
    vpipe = {vpipe[2:0], v};
    if (vpipe[3]) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        last = e;
      end
    end
    chk("valid_o", {63'd0, valid_o}, {63'd0, vpipe[3]});
    chk("X_o", {46'd0, X_o}, {46'd0, last.x});
    chk("d_o", {50'd0, d_o}, {50'd0, last.d});
    chk("flip_o", {63'd0, flip_o}, {63'd0, last.f});
  endtask

  task automatic model_reset();
    vpipe = '0;
    q.delete();
    last.x = '0;
    last.d = '0;
    last.f = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("rst_X_o", {46'd0, X_o}, 64'd0);
    chk("rst_d_o", {50'd0, d_o}, 64'd0);
    chk("rst_flip_o", {63'd0, flip_o}, 64'd0);
    rst_n = 1'b1;

    // (3000,4000): single vector, then bubbles
    cycle(1'b1, 3000, 4000);
    repeat (3) cycle(1'b0, 0, 0);
    xo = longint'($signed(X_o));
    chk("mag_3_4", {63'd0, (xo >= 4996 && xo <= 5004)}, 64'd1);
    chk("d0_3_4", {63'd0, d_o[0]}, 64'd0);
    rot_pe(3000, 4000, d_o, xs, ys);
    chk("loop_x_3_4", 64'(xs), 64'(xo));
    chk("loop_y_3_4", {63'd0, (ys >= -4 && ys <= 4)}, 64'd1);
    cycle(1'b0, 0, 0);
    xo = longint'($signed(X_o));
    chk("hold_mag_3_4", {63'd0, (xo >= 4996 && xo <= 5004)}, 64'd1);

    // (-3000,4000): left half-plane
    cycle(1'b1, -3000, 4000);
    repeat (3) cycle(1'b0, 0, 0);
    xo = longint'($signed(X_o));
    chk("mag_m3_4", {63'd0, (xo >= 4996 && xo <= 5004)}, 64'd1);
    chk("flip_m3_4", {63'd0, flip_o}, 64'd1);
    chk("d0_m3_4", {63'd0, d_o[0]}, 64'd1);
    rot_pe(3000, -4000, d_o, xs, ys);
    chk("loop_x_m3_4", 64'(xs), 64'(xo));
    chk("loop_y_m3_4", {63'd0, (ys >= -4 && ys <= 4)}, 64'd1);

    // (0,0)
    cycle(1'b1, 0, 0);
    repeat (3) cycle(1'b0, 0, 0);
    chk("zero_X_o", {46'd0, X_o}, 64'd0);
    chk("zero_d_o", {50'd0, d_o}, 64'd0);
    chk("zero_flip", {63'd0, flip_o}, 64'd0);

    // Most negative X in range of the sign-extended path
    cycle(1'b1, -65535, 65535);
    repeat (3) cycle(1'b0, 0, 0);

    // Back-to-back random stream; inputs restricted to |x|,|y| < 2^16
    for (int k = 0; k < 100; k++) begin
      longint rx, ry;
      rx = longint'($urandom_range(131070, 0)) - 65535;
      ry = longint'($urandom_range(131070, 0)) - 65535;
      assert (rx > -65536 && rx < 65536 && ry > -65536 && ry < 65536)
        else $error("FAIL input_range observed=%0d,%0d expected=|v|<65536", rx, ry);
      cycle(1'b1, rx, ry);
    end
    repeat (7) cycle(1'b0, 0, 0);

    // Reset with three vectors in flight; only the post-reset vector may emerge
    cycle(1'b1, 1234, -5678);
    cycle(1'b1, -20000, 300);
    cycle(1'b1, 40000, 40000);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_o", {63'd0, valid_o}, 64'd0);
    chk("midrst_X_o", {46'd0, X_o}, 64'd0);
    chk("midrst_d_o", {50'd0, d_o}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 7000, -2500);
    repeat (5) cycle(1'b0, 0, 0);
    chk("post_rst_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
